note_tone_gen: RTL
==================

// Module: note_tone_gen
// PURPOSE
//  Consumer end of the 16-bit note bus driven by the song/scale sequencers. Turns the
//  current note value (half-period in prescaled ticks) into a square-wave tone_out and
//  a signed 16-bit sample for the audio path. Period changes apply only at half-cycle
//  boundaries, so the output is glitch-free. A note value of 0 means rest.
// PARAMETERS
//  PRESCALE  16  clk50 cycles per tick; tick = 3.125 MHz at 50 MHz (range 2..256).
//  AMP_W     15  width of the amplitude input; sample_out is AMP_W+1 bits.
// PORTS
//  clk50       in   1   system clock, single clock domain
//  reset       in   1   asynchronous, active-high reset
//  enable      in   1   tone enable; 0 forces silence
//  note_in     in   16  half-period in ticks; 0 = rest. Held between sequencer steps.
//  amplitude   in   15  unsigned peak magnitude for sample_out
//  tone_out    out  1   square wave; 0 when idle
//  sample_out  out  16  signed: +amplitude in HIGH, -amplitude in LOW, 0 in IDLE
//  note_change out  1   1-cycle strobe when a latched period differs from the previous one
//  active      out  1   1 while in HIGH or LOW
// BEHAVIOUR
//  - Reset (async, any time, including mid-tone):
//    - State goes to IDLE.
//    - tone_out=0, sample_out=0, note_change=0, active=0.
//    - period_q=0, prescaler=0, half counter=0.
//  - Prescaler: counts 0..PRESCALE-1 and raises tick for one cycle at PRESCALE-1.
//    - Cleared on every IDLE->HIGH entry.
//    - Free-runs otherwise.
//  - FSM states: IDLE, HIGH, LOW. All outputs are registered.
//    - IDLE->HIGH: on the cycle after enable=1 and note_in!=0 are sampled.
//      - period_q<=note_in; half_cnt<=0.
//      - note_change pulses if note_in!=period_q.
//    - HIGH/LOW: half_cnt increments on each tick.
//      - Boundary: tick && half_cnt==period_q-1.
//      - At the boundary, half_cnt<=0 and note_in is re-sampled:
//        - note_in==0: go to IDLE.
//        - otherwise: toggle HIGH<->LOW and set period_q<=note_in.
//        - note_change pulses on that cycle if the value differs.
//    - A change in note_in mid-half has no effect until the next boundary.
//    - enable=0 in HIGH or LOW: go to IDLE on the next cycle (immediate mute).
//      - period_q is retained, so re-enabling with the same note gives no note_change.
//  - Timing:
//    - One half-period lasts exactly period_q*PRESCALE clk50 cycles.
//    - Exception: the first half after IDLE is exact because the prescaler is cleared.
//    - note_in=1 is legal: toggling every tick.
//    - Latency from note_in/enable sample to tone_out=1 is 1 cycle.
//  - Arithmetic:
//    - sample_out = {1'b0,amplitude} in HIGH; its two's complement in LOW.
//    - amplitude=0 gives sample_out=0 in every state.
//    - half_cnt is 16 bits. Compare against period_q-1; no wrap is possible since period_q>=1.
//  - Simultaneous events, in priority order: reset > enable=0 > boundary.
//    - If enable falls on a boundary cycle, the FSM goes to IDLE and period_q is not updated.
// STRUCTURE
//  - Shared package synth_pkg:
//    - State enum {IDLE, HIGH, LOW} (2-bit encoding).
//    - NOTE_W=16.
//    - DEFAULT_PRESCALE=16.
//    - NOTE_REST=16'd0.
//  - One sub-module, tick_prescaler:
//    - Parameterised by PRESCALE.
//    - Inputs clk50, reset, clear; output tick.
//  - The FSM, half counter and output registers stay in note_tone_gen.
// TESTING
//  - Reset: assert reset mid-HIGH -> all outputs 0 within the same cycle (async). After
//    release with enable=0, outputs stay 0.
//  - PRESCALE=4, note_in=3, enable=1 -> tone_out high 12 cycles, low 12 cycles, repeating;
//    sample_out = +amplitude/-amplitude in step; one note_change at start.
//  - Change note_in 3->5 in the middle of HIGH -> current HIGH still lasts 12 cycles; the
//    following LOW lasts 20 cycles; note_change pulses exactly at that boundary.
//  - note_in->0 mid-LOW -> LOW completes its full length, then IDLE; tone_out=0, active=0.
//  - enable dropped mid-HIGH -> IDLE the next cycle. Re-enable with the same note ->
//    HIGH after 1 cycle, no note_change, first half is exactly period*PRESCALE cycles.
//  - note_in=1, PRESCALE=2 -> tone_out toggles every 2 cycles.
//    Also: enable falls on a boundary cycle -> IDLE, period_q unchanged.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the note bus and the tone generator.
package synth_pkg;

    localparam int unsigned NOTE_W           = 16;
    localparam int unsigned DEFAULT_PRESCALE = 16;
    localparam logic [NOTE_W-1:0] NOTE_REST  = 16'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    function automatic logic is_rest(input logic [NOTE_W-1:0] note);
        return note == NOTE_REST;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk50 down to a one-cycle tick every PRESCALE cycles; clear restarts the phase.
module tick_prescaler
    import synth_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick is registered yet still coincides with the cycle where cnt_q == CNT_MAX
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator fed by the note bus; period changes only land on half-cycle
// boundaries so tone_out and sample_out never glitch.
module note_tone_gen
    import synth_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned AMP_W    = 15
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              enable,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [AMP_W-1:0]  amplitude,
    output logic              tone_out,
    output logic [AMP_W:0]    sample_out,
    output logic              note_change,
    output logic              active
);

    localparam int unsigned SAMPLE_W = AMP_W + 1;

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   period_q, period_d;
    logic [NOTE_W-1:0]   half_cnt_q, half_cnt_d;
    logic                tick;
    logic                prescale_clr;
    logic                boundary;
    logic                period_load;
    logic                note_nz;

    logic                tone_out_q, tone_out_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                note_change_q, note_change_d;
    logic                active_q, active_d;

    assign note_nz = !is_rest(note_in);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk50 (clk50),
        .reset (reset),
        .clear (prescale_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            period_q   <= '0;
            half_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            half_cnt_q <= half_cnt_d;
        end
    end

    // Next state: enable=0 outranks a half-cycle boundary
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        half_cnt_d   = half_cnt_q;
        prescale_clr = 1'b0;
        period_load  = 1'b0;
        boundary     = tick && (half_cnt_q == (period_q - NOTE_W'(1)));

        unique case (state_q)
            IDLE: begin
                half_cnt_d = '0;
                if (enable && note_nz) begin
                    state_d      = HIGH;
                    period_d     = note_in;
                    period_load  = 1'b1;
                    prescale_clr = 1'b1;
                end
            end
            HIGH, LOW: begin
                if (!enable) begin
                    state_d    = IDLE;
                    half_cnt_d = '0;
                end else if (boundary) begin
                    half_cnt_d = '0;
                    if (!note_nz) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = (state_q == HIGH) ? LOW : HIGH;
                        period_d    = note_in;
                        period_load = 1'b1;
                    end
                end else if (tick) begin
                    half_cnt_d = half_cnt_q + NOTE_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                half_cnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge
    always_comb begin
        tone_out_d    = 1'b0;
        active_d      = 1'b0;
        sample_d      = '0;
        note_change_d = period_load && (note_in != period_q);

        unique case (state_d)
            HIGH: begin
                tone_out_d = 1'b1;
                active_d   = 1'b1;
                sample_d   = {1'b0, amplitude};
            end
            LOW: begin
                active_d = 1'b1;
                sample_d = -{1'b0, amplitude};
            end
            default: begin
                tone_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            tone_out_q    <= 1'b0;
            sample_q      <= '0;
            note_change_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            tone_out_q    <= tone_out_d;
            sample_q      <= sample_d;
            note_change_q <= note_change_d;
            active_q      <= active_d;
        end
    end

    assign tone_out    = tone_out_q;
    assign sample_out  = sample_q;
    assign note_change = note_change_q;
    assign active      = active_q;

endmodule
